// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready handshakes. Logic, arithmetic and compare
// ops finish in one cycle; shifts iterate one bit per cycle.
module alu_seq_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [XLEN-1:0]     result_reg, result_next;
  logic [XLEN-1:0]     shift_reg, shift_next;
  logic [SHAMT_W-1:0]  cnt_reg, cnt_next;
  logic [3:0]          op_reg, op_next;

  logic [XLEN-1:0]     alu_res;
  logic [XLEN-1:0]     shift_step;
  logic [SHAMT_W-1:0]  shamt;
  logic                is_shift;

  assign shamt    = op_b[SHAMT_W-1:0];
  assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                    (alu_control == OP_SRA);

  // Single-cycle ops; reserved codes 1010..1111 fall through to ADD.
  always_comb begin
    alu_res = op_a + op_b;
    case (alu_control)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    case (op_reg)
      OP_SLL:  shift_step = {shift_reg[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, shift_reg[XLEN-1:1]};
      default: shift_step = {shift_reg[XLEN-1], shift_reg[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!is_shift) begin
            result_next = alu_res;
            state_next  = DONE;
          end else if (shamt == '0) begin
            result_next = op_a;
            state_next  = DONE;
          end else begin
            shift_next = op_a;
            cnt_next   = shamt;
            op_next    = alu_control;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        shift_next = shift_step;
        cnt_next   = cnt_reg - SHAMT_W'(1);
        if (cnt_reg == SHAMT_W'(1)) begin
          result_next = shift_step;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flush aborts everything and leaves the last published result untouched.
    if (flush) begin
      state_next  = IDLE;
      cnt_next    = '0;
      result_next = result_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      op_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
    end
  end

  // in_ready is gated by rst_n so it stays low while reset is held.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;
  assign zero      = (result_reg == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed vectors push expectations, a
// negedge monitor pops and checks on every output handshake.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'b0000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          txn_id = 0;
  logic [31:0] last_res = '0;

  alu_seq_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got %h expected none", result);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: result=%h zero=%b (exp %h/%b)", e.id, result, zero, e.res, e.z);
          chk($sformatf("txn%0d_result", e.id), result, e.res);
          chk($sformatf("txn%0d_zero", e.id), {31'b0, zero}, {31'b0, e.z});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    in_valid = 1'b1; alu_control = code; op_a = a; op_b = b;
    @(posedge clk); #1;
    // Scramble inputs after accept; they must not affect the op.
    in_valid = 1'b0; alu_control = 4'b0011; op_a = 32'hA5A5_5A5A; op_b = 32'h0000_0013;
  endtask

  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    exp_q.push_back('{exp, (exp == 32'd0), txn_id});
    issue(code, a, b);
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk($sformatf("txn%0d_latency", txn_id), lat, exp_lat);
    last_res = exp;
    txn_id++;
    if (out_ready) begin
      @(posedge clk); #1;
      chk("drain_valid_ready", {30'b0, out_valid, in_ready}, 32'b01);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic saw;
    // Reset state while rst_n is held low
    #2;
    chk("reset_state", {result, zero, out_valid, busy, in_ready},
        {32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);  // ADD
    run_op(4'b0110, 32'd5, 32'd5, 32'h0, 0);                          // SUB
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);                  // SLT
    run_op(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);                  // SLTU
    run_op(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0);  // AND
    run_op(4'b0001, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 0);  // OR
    run_op(4'b1000, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 31); // SRA
    run_op(4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 31); // SRL
    run_op(4'b0100, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 0);  // SLL shamt 0
    run_op(4'b1111, 32'd3, 32'd4, 32'd7, 0);                          // reserved -> ADD
    run_op(4'b0100, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 4);  // SLL 4
    run_op(4'b0101, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 4);  // SRL, upper b ignored

    // Backpressure: XOR held for 5 cycles
    out_ready = 1'b0;
    run_op(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_%0d", i), {out_valid, in_ready, result[29:0]},
          {1'b1, 1'b0, 30'h0F0F_0F0F});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'b0, out_valid, in_ready}, 32'b01);

    // flush together with in_valid in IDLE: flush wins
    in_valid = 1'b1; flush = 1'b1; alu_control = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_beats_valid", {29'b0, busy, out_valid, in_ready}, 32'b001);

    // flush mid-SHIFT (4th SHIFT cycle)
    issue(4'b0100, 32'h0000_0001, 32'h0000_000A);
    repeat (3) begin @(posedge clk); #1; end
    chk("shift_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_to_idle", {29'b0, busy, out_valid, in_ready}, 32'b001);
    chk("flush_result_hold", result, last_res);
    saw = 1'b0;
    repeat (15) begin @(posedge clk); #1; saw = saw | out_valid; end
    chk("flush_no_valid", {31'b0, saw}, 32'd0);

    // flush together with out_ready in DONE: consumed once
    out_ready = 1'b0;
    run_op(4'b0010, 32'd10, 32'd20, 32'd30, 0);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_drain", {30'b0, out_valid, in_ready}, 32'b01);

    // Reset pulsed mid-SHIFT
    issue(4'b0100, 32'h0000_0001, 32'h0000_000A);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midshift_reset", {result, zero, out_valid, busy, in_ready},
        {32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    saw = 1'b0;
    repeat (15) begin @(posedge clk); #1; saw = saw | out_valid; end
    chk("reset_no_valid", {31'b0, saw}, 32'd0);

    run_op(4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 0);                  // SUB wraps

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that sits directly downstream of the ALU controller.
- Consumes the 4-bit alu_control code plus two operands and returns a registered result and a zero flag.
- Uses a valid/ready handshake on both input and output.
- Logic/arithmetic/compare ops complete in one cycle; shifts run iteratively at one bit per cycle, so the datapath needs no barrel shifter.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; shamt = op_b[SHAMT_W-1:0]; must equal log2(XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation
- alu_control  input  4  operation code (encoding below)
- op_a  input  XLEN  operand A (rs1 / PC)
- op_b  input  XLEN  operand B (rs2 / immediate)
- flush  input  1  synchronous abort of any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  operation result
- zero  output  1  result == 0
- busy  output  1  state != IDLE

Behaviour:
- alu_control encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed)
  - 1000 SRA, 1001 SLTU
  - 1010..1111 execute as ADD.
- Arithmetic: ADD/SUB are modulo 2^XLEN; overflow is ignored. SLT/SLTU return 1 or 0 in bit 0, with upper bits zero.
- Reset (rst_n low, asynchronous):
  - state=IDLE, result=0, zero=1, out_valid=0, busy=0, shift counter=0.
  - in_ready goes high only after rst_n deasserts.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, the op is accepted at that edge.
  - Non-shift op: compute, register result, go to DONE.
  - Shift op with shamt=0: result=op_a, go to DONE.
  - Shift op with shamt=k>0: load op_a into the shift register, cnt=k, latch the op, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, shift one bit: SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates the MSB. Then cnt-=1.
  - When cnt reaches 0 on that edge, go to DONE.
- DONE:
  - out_valid=1; result and zero are stable.
  - On out_ready, go to IDLE, where out_valid=0.
  - No accept occurs in the same cycle as drain; max throughput is one op per 2 cycles.
- Latency:
  - Non-shift op or shamt=0: out_valid is high in the cycle immediately after the accept cycle.
  - Shift with shamt=k: out_valid rises k cycles later than that.
- zero is combinational from the registered result and is valid whenever out_valid=1.
- Operands are sampled only at the accept edge. Changes on op_a/op_b/alu_control after accept have no effect.
- flush:
  - In any state, flush forces IDLE at the next edge: out_valid=0, cnt=0; result holds its last value.
  - flush and in_valid together in IDLE: flush wins; the op is not accepted and in_ready stays 1.
  - flush and out_ready together in DONE: the result is consumed once and the block goes to IDLE.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is discarded.
- out_valid never drops without an out_ready handshake except by flush or reset.
- Shift count of XLEN-1 (31) is the maximum and completes in 31 SHIFT cycles. Upper op_b bits are ignored.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 with out_ready=1 -> one cycle after accept: result=0x80000000, zero=0, out_valid for exactly 1 cycle.
- SUB 5 - 5, then SLT 0xFFFFFFFF vs 1, then SLTU 0xFFFFFFFF vs 1 -> result 0 with zero=1; then 1; then 0.
- SRA op_a=0x80000000, op_b=0x0000001F -> busy for 31 SHIFT cycles; out_valid appears 31 cycles after the non-shift latency; result=0xFFFFFFFF. SRL of the same operands -> 0x00000001.
- SLL op_a=0x1, op_b=0x20 (shamt=0) -> one-cycle latency, result=0x00000001. Code 1111 with 3,4 -> result=7.
- Backpressure: XOR 0xF0F0F0F0 ^ 0xFFFFFFFF with out_ready=0 for 5 cycles -> out_valid held, result=0x0F0F0F0F stable, in_ready=0. After out_ready pulses, the next cycle shows in_ready=1.
- SLL shamt=10 with flush at 4th SHIFT cycle -> IDLE next edge, out_valid never rises. Repeat with rst_n pulsed low mid-SHIFT -> outputs immediately at reset values (result=0, zero=1).
